// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - Period-aligned duty slew sequencer for a PWM generator
// Accepts target duty/period commands and steps the applied duty toward target on PWM period boundaries.
module pwm_ramp_ctrl #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] DEF_PERIOD = 32'd1000,
  parameter logic [WIDTH-1:0] RAMP_STEP  = 32'd10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [WIDTH-1:0] cmd_duty_i,
  input  logic [WIDTH-1:0] cmd_period_i,
  input  logic             estop_i,
  output logic [WIDTH-1:0] duty_val_o,
  output logic             val_en_o,
  output logic [WIDTH-1:0] max_duty_o,
  output logic             at_target_o,
  output logic             sat_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RAMP  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_ESTOP = 2'd3;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0] max_duty_q, max_duty_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] duty_val_q, duty_val_d;
  logic             val_en_q, val_en_d;
  logic             at_target_q, at_target_d;
  logic             sat_q, sat_d;

  logic             tick;
  logic             accept;
  logic [WIDTH:0]   lim_w;
  logic [WIDTH-1:0] lim;
  logic             clamp_hit;
  logic [WIDTH-1:0] clamp_duty;
  logic [WIDTH-1:0] tgt_eff;
  logic             ramp_up;
  logic [WIDTH-1:0] gap;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] cur_step;

  function automatic logic [1:0] rest_state(input logic [WIDTH-1:0] v);
    return (v == '0) ? S_IDLE : S_HOLD;
  endfunction

  // pcnt shadows the generator's own counter; both leave reset at 0 so they stay in phase.
  assign tick        = (pcnt_q >= max_duty_q);
  assign cmd_ready_o = (state_q != S_ESTOP) && !estop_i;
  assign accept      = cmd_valid_i && cmd_ready_o;

  // Duty may legitimately equal period+1 (always high); saturate that limit at the top code.
  assign lim_w      = {1'b0, cmd_period_i} + {{WIDTH{1'b0}}, 1'b1};
  assign lim        = lim_w[WIDTH] ? '1 : lim_w[WIDTH-1:0];
  assign clamp_hit  = (cmd_duty_i > lim);
  assign clamp_duty = clamp_hit ? lim : cmd_duty_i;

  // A command landing on a tick cycle already steers that tick's step.
  assign tgt_eff  = accept ? clamp_duty : target_q;
  assign ramp_up  = (tgt_eff > cur_q);
  assign gap      = ramp_up ? (tgt_eff - cur_q) : (cur_q - tgt_eff);
  assign step     = (gap > RAMP_STEP) ? RAMP_STEP : gap;
  assign cur_step = ramp_up ? (cur_q + step) : (cur_q - step);

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    target_d   = target_q;
    duty_val_d = duty_val_q;
    val_en_d   = 1'b0;
    sat_d      = sat_q;

    pcnt_d     = tick ? '0 : (pcnt_q + ONE);
    pend_d     = accept ? cmd_period_i : pend_q;
    max_duty_d = tick ? pend_d : max_duty_q;

    if (estop_i) begin
      state_d = S_ESTOP;
      if (state_q != S_ESTOP) begin
        cur_d      = '0;
        target_d   = '0;
        duty_val_d = '0;
        val_en_d   = 1'b1;
      end
    end else if (state_q == S_ESTOP) begin
      state_d = S_IDLE;
    end else begin
      if (accept) begin
        target_d = clamp_duty;
        sat_d    = clamp_hit;
        state_d  = (clamp_duty == cur_q) ? rest_state(cur_q) : S_RAMP;
      end
      if ((state_q == S_RAMP) && (state_d == S_RAMP) && tick) begin
        cur_d      = cur_step;
        duty_val_d = cur_step;
        val_en_d   = 1'b1;
        if (cur_step == tgt_eff) begin
          state_d = rest_state(cur_step);
        end
      end
    end

    at_target_d = (state_d == S_IDLE) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      pcnt_q      <= '0;
      max_duty_q  <= DEF_PERIOD;
      pend_q      <= DEF_PERIOD;
      cur_q       <= '0;
      target_q    <= '0;
      duty_val_q  <= '0;
      val_en_q    <= 1'b0;
      at_target_q <= 1'b1;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      max_duty_q  <= max_duty_d;
      pend_q      <= pend_d;
      cur_q       <= cur_d;
      target_q    <= target_d;
      duty_val_q  <= duty_val_d;
      val_en_q    <= val_en_d;
      at_target_q <= at_target_d;
      sat_q       <= sat_d;
    end
  end

  assign duty_val_o  = duty_val_q;
  assign val_en_o    = val_en_q;
  assign max_duty_o  = max_duty_q;
  assign at_target_o = at_target_q;
  assign sat_o       = sat_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - Self-checking bench for pwm_ramp_ctrl
// Directed vectors plus hand sequences; a generator counter model checks tick alignment.
module tb_pwm_ramp_ctrl;
  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [W-1:0] cmd_duty_i;
  logic [W-1:0] cmd_period_i;
  logic         estop_i;
  logic [W-1:0] duty_val_o;
  logic         val_en_o;
  logic [W-1:0] max_duty_o;
  logic         at_target_o;
  logic         sat_o;

  always #5 clk_i = ~clk_i;

  pwm_ramp_ctrl #(.WIDTH(32), .DEF_PERIOD(32'd1000), .RAMP_STEP(32'd10)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_duty_i(cmd_duty_i), .cmd_period_i(cmd_period_i), .estop_i(estop_i),
    .duty_val_o(duty_val_o), .val_en_o(val_en_o), .max_duty_o(max_duty_o),
    .at_target_o(at_target_o), .sat_o(sat_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Generator model: counter wraps at max, max reloads from the pending period on a tick.
  logic [W-1:0] m_cnt, m_max, m_pend, m_pend_nx;
  logic         m_est, m_tick_q, m_tick, m_acc, m_ready;
  int unsigned  cyc = 0;

  assign m_tick    = (m_cnt >= m_max);
  assign m_ready   = !estop_i && !m_est;
  assign m_acc     = cmd_valid_i && m_ready;
  assign m_pend_nx = m_acc ? cmd_period_i : m_pend;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_cnt <= '0; m_max <= 32'd1000; m_pend <= 32'd1000; m_est <= 1'b0; m_tick_q <= 1'b0;
    end else begin
      m_cnt    <= m_tick ? '0 : m_cnt + 1;
      m_max    <= m_tick ? m_pend_nx : m_max;
      m_pend   <= m_pend_nx;
      m_est    <= estop_i;
      m_tick_q <= m_tick;
    end
  end

  typedef struct {
    logic [W-1:0] duty;
    int unsigned  cyc;
    logic         tk;
    logic         at;
  } pulse_t;

  pulse_t pq[$];
  pulse_t mon_p;
  int max_bad = 0;
  int rdy_bad = 0;

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (val_en_o) begin
        mon_p.duty = duty_val_o; mon_p.cyc = cyc; mon_p.tk = m_tick_q; mon_p.at = at_target_o;
        pq.push_back(mon_p);
      end
      if (max_duty_o !== m_max) max_bad++;
      if (cmd_ready_o !== m_ready) rdy_bad++;
    end
  end

  typedef struct {
    logic [W-1:0] duty;
    logic [W-1:0] period;
    logic         sat;
    logic [W-1:0] fin;
    int           np;
  } vec_t;

  vec_t         tbl[6];
  logic [W-1:0] ex[8];

  task automatic step_clk();
    @(posedge clk_i);
    #2;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] p, input string nm);
    cmd_valid_i = 1'b1; cmd_duty_i = d; cmd_period_i = p;
    #1;
    chk({nm, " cmd_ready"}, cmd_ready_o, 1);
    step_clk();
    cmd_valid_i = 1'b0;
  endtask

  task automatic sync_tick(input string nm);
    int k = 0;
    step_clk();
    while (!m_tick_q && k < 2000) begin step_clk(); k++; end
    chk({nm, " sync tick"}, m_tick_q, 1);
  endtask

  task automatic wait_pulses(input int n, input int budget, input string nm);
    int k = 0;
    while (pq.size() < n && k < budget) begin step_clk(); k++; end
    chk({nm, " pulse wait"}, (pq.size() >= n), 1);
  endtask

  function automatic logic [63:0] pduty(input int i);
    return (i < pq.size()) ? {32'd0, pq[i].duty} : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic check_pulses(input string nm, input int n, input int unsigned gap);
    chk({nm, " pulse count"}, pq.size(), n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s pulse%0d duty", nm, i), pduty(i), ex[i]);
      chk($sformatf("%s pulse%0d on tick", nm, i), (i < pq.size()) ? pq[i].tk : 1'bx, 1);
      if (gap != 0 && i > 0 && i < pq.size())
        chk($sformatf("%s pulse%0d spacing", nm, i), pq[i].cyc - pq[i-1].cyc, gap);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int k;
    int unsigned sw;
    tbl[0] = '{32'd40,  32'd50, 1'b0, 32'd40, 2};
    tbl[1] = '{32'd100, 32'd50, 1'b1, 32'd51, 2};
    tbl[2] = '{32'd51,  32'd50, 1'b0, 32'd51, 0};
    tbl[3] = '{32'd0,   32'd59, 1'b0, 32'd0,  6};
    tbl[4] = '{32'd7,   32'd59, 1'b0, 32'd7,  1};
    tbl[5] = '{32'd70,  32'd59, 1'b1, 32'd60, 6};

    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_duty_i = '0; cmd_period_i = '0; estop_i = 1'b0;
    repeat (3) step_clk();
    rst_ni = 1'b1;

    chk("t1 duty_val", duty_val_o, 0);
    chk("t1 max_duty", max_duty_o, 1000);
    chk("t1 val_en", val_en_o, 0);
    chk("t1 cmd_ready", cmd_ready_o, 1);
    chk("t1 at_target", at_target_o, 1);
    chk("t1 sat", sat_o, 0);
    repeat (1100) step_clk();
    chk("t1 no val_en", pq.size(), 0);

    sync_tick("t2");
    send(32'd35, 32'd1000, "t2");
    wait_pulses(4, 5000, "t2");
    repeat (1100) step_clk();
    ex = '{32'd10, 32'd20, 32'd30, 32'd35, 32'd0, 32'd0, 32'd0, 32'd0};
    check_pulses("t2", 4, 1001);
    chk("t2 at_target before last", (pq.size() > 2) ? pq[2].at : 1'bx, 0);
    chk("t2 at_target on last", (pq.size() > 3) ? pq[3].at : 1'bx, 1);
    chk("t2 at_target hold", at_target_o, 1);

    pq.delete();
    sync_tick("t6");
    send(32'd35, 32'd200, "t6");
    chk("t6 max_duty before tick", max_duty_o, 1000);
    k = 0;
    while (max_duty_o != 32'd200 && k < 1100) begin step_clk(); k++; end
    sw = cyc;
    chk("t6 max_duty switch", max_duty_o, 200);
    chk("t6 switch latency", k, 1000);
    chk("t6 hold no val_en", pq.size(), 0);
    send(32'd55, 32'd200, "t6r");
    wait_pulses(2, 600, "t6r");
    ex = '{32'd45, 32'd55, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    check_pulses("t6r", 2, 201);
    chk("t6 first interval", (pq.size() > 0) ? pq[0].cyc - sw : 0, 201);

    for (int r = 0; r < 6; r++) begin
      pq.delete();
      sync_tick($sformatf("vec%0d", r));
      send(tbl[r].duty, tbl[r].period, $sformatf("vec%0d", r));
      repeat ((tbl[r].np + 2) * 202 + 10) step_clk();
      chk($sformatf("vec%0d pulses", r), pq.size(), tbl[r].np);
      chk($sformatf("vec%0d duty_val", r), duty_val_o, tbl[r].fin);
      chk($sformatf("vec%0d sat", r), sat_o, tbl[r].sat);
      chk($sformatf("vec%0d at_target", r), at_target_o, 1);
      chk($sformatf("vec%0d max_duty", r), max_duty_o, tbl[r].period);
      k = 0;
      foreach (pq[i]) if (!pq[i].tk) k++;
      chk($sformatf("vec%0d off-tick pulses", r), k, 0);
    end

    pq.delete();
    sync_tick("t3");
    send(32'd5000, 32'd999, "t3a");
    chk("t3 clamp sat", sat_o, 1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, "t3b");
    chk("t3 full range sat", sat_o, 0);
    send(32'd60, 32'd59, "t3c");
    chk("t3 edge sat", sat_o, 0);
    repeat (130) step_clk();
    chk("t3 no val_en", pq.size(), 0);
    chk("t3 max_duty", max_duty_o, 59);
    chk("t3 duty_val", duty_val_o, 60);
    chk("t3 at_target", at_target_o, 1);

    sync_tick("t4a");
    send(32'd0, 32'd59, "t4a");
    wait_pulses(6, 600, "t4a");
    repeat (70) step_clk();
    ex = '{32'd50, 32'd40, 32'd30, 32'd20, 32'd10, 32'd0, 32'd0, 32'd0};
    check_pulses("t4a", 6, 60);
    pq.delete();
    sync_tick("t4b");
    send(32'd35, 32'd59, "t4b");
    wait_pulses(2, 300, "t4b");
    send(32'd0, 32'd59, "t4c");
    wait_pulses(4, 300, "t4c");
    repeat (130) step_clk();
    ex = '{32'd10, 32'd20, 32'd10, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    check_pulses("t4", 4, 60);
    chk("t4 at_target mid", (pq.size() > 2) ? pq[2].at : 1'bx, 0);
    chk("t4 idle", at_target_o, 1);
    chk("t4 duty_val", duty_val_o, 0);

    pq.delete();
    sync_tick("t5");
    send(32'd50, 32'd59, "t5");
    wait_pulses(1, 200, "t5");
    repeat (5) step_clk();
    estop_i = 1'b1; cmd_valid_i = 1'b1; cmd_duty_i = 32'd30; cmd_period_i = 32'd59;
    #1;
    chk("t5 ready during estop", cmd_ready_o, 0);
    step_clk();
    chk("t5 estop val_en", val_en_o, 1);
    chk("t5 estop duty", duty_val_o, 0);
    chk("t5 estop at_target", at_target_o, 0);
    repeat (150) step_clk();
    chk("t5 single estop pulse", pq.size(), 2);
    chk("t5 estop max_duty", max_duty_o, 59);
    chk("t5 estop val_en low", val_en_o, 0);
    estop_i = 1'b0;
    #1;
    chk("t5 ready in release cycle", cmd_ready_o, 0);
    step_clk();
    cmd_valid_i = 1'b0;
    chk("t5 idle after release", at_target_o, 1);
    chk("t5 ready after release", cmd_ready_o, 1);
    repeat (150) step_clk();
    chk("t5 release cmd ignored", pq.size(), 2);
    chk("t5 duty stays 0", duty_val_o, 0);

    pq.delete();
    sync_tick("t7");
    send(32'd50, 32'd59, "t7");
    wait_pulses(1, 200, "t7");
    repeat (3) step_clk();
    #1 rst_ni = 1'b0;
    #1;
    chk("t7 async duty_val", duty_val_o, 0);
    chk("t7 async max_duty", max_duty_o, 1000);
    chk("t7 async at_target", at_target_o, 1);
    chk("t7 async val_en", val_en_o, 0);
    step_clk();
    rst_ni = 1'b1;
    repeat (100) step_clk();
    chk("t7 no pulse after reset", pq.size(), 1);

    chk("max_duty tracks generator model", max_bad, 0);
    chk("cmd_ready tracks model", rdy_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
